// File: rtl/mux_pkg.sv
// Shared definitions for the mux-driven serializer.
//   state_t : serializer FSM states
//   SEL_W   : width of the 8:1 mux select
//   N_IN    : number of mux data inputs (bits per serialized word)
package mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int SEL_W = 3;
  localparam int N_IN  = 8;

endpackage : mux_pkg

// File: rtl/mux8x1.sv
// Existing 8:1 single-bit multiplexer.
//   i : eight data inputs
//   s : select
//   y : selected bit, i[s]
module mux8x1 (
  input  logic [7:0] i,
  input  logic [2:0] s,
  output logic       y
);

  assign y = i[s];

endmodule : mux8x1

// File: rtl/mux_serializer.sv
// Parallel-to-serial stage built around the 8:1 mux. A byte is captured on an
// in_valid/in_ready handshake and then emitted one bit per accepted beat on a
// ser_valid/ser_ready stream. The emitted bit is the mux output data_reg[sel].
//   clk, rst_n : clock, asynchronous active-low reset
//   in_data, in_valid, in_ready   : byte-wide input handshake
//   ser_bit, ser_valid, ser_ready : bit-serial output handshake
//   ser_last   : current bit is the final bit of the word
//   sel        : current mux select (debug / coverage)
//   busy       : a word is in flight
module mux_serializer
  import mux_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  localparam logic [SEL_W-1:0] SEL_START = MSB_FIRST ? SEL_W'(N_IN - 1) : '0;
  localparam logic [SEL_W-1:0] SEL_END   = MSB_FIRST ? '0 : SEL_W'(N_IN - 1);

  state_t           state, state_nxt;
  logic [N_IN-1:0]  data_reg, data_nxt;
  logic [SEL_W-1:0] sel_nxt;
  logic             in_fire;
  logic             ser_fire;

  // ser_bit comes straight from registered data and select, so the serial
  // output has no combinational path from any input.
  mux8x1 u_mux (
    .i (data_reg),
    .s (sel),
    .y (ser_bit)
  );

  assign ser_valid = (state == SEND);
  assign busy      = (state == SEND);
  assign ser_last  = (state == SEND) && (sel == SEL_END);
  // Reopening the input on the accepted last beat is what allows
  // back-to-back words with no idle cycle in between.
  assign in_ready  = (state == IDLE) || (ser_last && ser_ready);
  assign in_fire   = in_valid && in_ready;
  assign ser_fire  = ser_valid && ser_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_reg <= '0;
      sel      <= SEL_START;
    end else begin
      state    <= state_nxt;
      data_reg <= data_nxt;
      sel      <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = data_reg;
    sel_nxt   = sel;
    case (state)
      IDLE: begin
        if (in_fire) begin
          data_nxt  = in_data;
          sel_nxt   = SEL_START;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (ser_fire) begin
          if (ser_last) begin
            sel_nxt = SEL_START;
            if (in_fire) begin
              data_nxt  = in_data;
              state_nxt = SEND;
            end else begin
              state_nxt = IDLE;
            end
          end else if (MSB_FIRST) begin
            sel_nxt = sel - SEL_W'(1);
          end else begin
            sel_nxt = sel + SEL_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule : mux_serializer

// File: tb/tb_mux_serializer.sv
module tb_mux_serializer;

  typedef struct {
    logic       b;
    logic       last;
    logic [2:0] sel;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // LSB-first instance
  logic [7:0] in_data_l = 8'h00;
  logic       in_valid_l = 1'b0;
  logic       in_ready_l;
  logic       ser_bit_l, ser_valid_l, ser_last_l, busy_l;
  logic       ser_ready_l = 1'b1;
  logic [2:0] sel_l;

  // MSB-first instance
  logic [7:0] in_data_m = 8'h00;
  logic       in_valid_m = 1'b0;
  logic       in_ready_m;
  logic       ser_bit_m, ser_valid_m, ser_last_m, busy_m;
  logic       ser_ready_m = 1'b1;
  logic [2:0] sel_m;

  beat_t q_l[$];
  beat_t q_m[$];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_serializer #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data_l), .in_valid(in_valid_l), .in_ready(in_ready_l),
    .ser_bit(ser_bit_l), .ser_valid(ser_valid_l), .ser_ready(ser_ready_l),
    .ser_last(ser_last_l), .sel(sel_l), .busy(busy_l)
  );

  mux_serializer #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data_m), .in_valid(in_valid_m), .in_ready(in_ready_m),
    .ser_bit(ser_bit_m), .ser_valid(ser_valid_m), .ser_ready(ser_ready_m),
    .ser_last(ser_last_m), .sel(sel_m), .busy(busy_m)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop one expected beat per accepted serial beat.
  always @(negedge clk) begin
    if (rst_n && ser_valid_l && ser_ready_l) begin
      if (q_l.size() == 0) begin
        check("lsb_unexpected_beat", 8'd1, 8'd0);
      end else begin
        beat_t e;
        e = q_l.pop_front();
        check("lsb_beat{bit,last,sel}", {3'b0, ser_bit_l, ser_last_l, sel_l},
              {3'b0, e.b, e.last, e.sel});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ser_valid_m && ser_ready_m) begin
      if (q_m.size() == 0) begin
        check("msb_unexpected_beat", 8'd1, 8'd0);
      end else begin
        beat_t e;
        e = q_m.pop_front();
        check("msb_beat{bit,last,sel}", {3'b0, ser_bit_m, ser_last_m, sel_m},
              {3'b0, e.b, e.last, e.sel});
      end
    end
  end

  // exp[k] is the k-th bit expected on the wire.
  task automatic push_lsb(input bit exp [8]);
    for (int k = 0; k < 8; k++) begin
      beat_t e;
      e.b = exp[k]; e.last = (k == 7); e.sel = 3'(k);
      q_l.push_back(e);
    end
  endtask

  task automatic push_msb(input bit exp [8]);
    for (int k = 0; k < 8; k++) begin
      beat_t e;
      e.b = exp[k]; e.last = (k == 7); e.sel = 3'(7 - k);
      q_m.push_back(e);
    end
  endtask

  task automatic put_lsb(input logic [7:0] w, input bit exp [8]);
    bit done;
    done = 1'b0;
    push_lsb(exp);
    in_data_l  = w;
    in_valid_l = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      done = in_ready_l;
      @(posedge clk); #1;
    end
    if (!done) check("lsb_capture_timeout", 8'd0, 8'd1);
    in_valid_l = 1'b0;
  endtask

  task automatic put_msb(input logic [7:0] w, input bit exp [8]);
    bit done;
    done = 1'b0;
    push_msb(exp);
    in_data_m  = w;
    in_valid_m = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      done = in_ready_m;
      @(posedge clk); #1;
    end
    if (!done) check("msb_capture_timeout", 8'd0, 8'd1);
    in_valid_m = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((q_l.size() != 0 || q_m.size() != 0) && c < 200) begin
      @(posedge clk); #1;
      c++;
    end
    if (q_l.size() != 0 || q_m.size() != 0)
      check("drain_timeout", 8'(q_l.size() + q_m.size()), 8'd0);
    @(negedge clk);
  endtask

  initial begin
    int caps;
    int k;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {7'b0, in_ready_l}, 8'd1);
    check("rst_ser_valid", {7'b0, ser_valid_l}, 8'd0);
    check("rst_ser_bit", {7'b0, ser_bit_l}, 8'd0);
    check("rst_ser_last", {7'b0, ser_last_l}, 8'd0);
    check("rst_sel_lsb", {5'b0, sel_l}, 8'd0);
    check("rst_busy", {7'b0, busy_l}, 8'd0);
    check("rst_sel_msb", {5'b0, sel_m}, 8'd7);
    @(posedge clk); #1;

    // LSB-first, 8'hA5
    put_lsb(8'hA5, '{1,0,1,0,0,1,0,1});
    // MSB-first, 8'h81
    put_msb(8'h81, '{1,0,0,0,0,0,0,1});
    drain();
    check("idle_busy_lsb", {7'b0, busy_l}, 8'd0);
    check("idle_valid_lsb", {7'b0, ser_valid_l}, 8'd0);
    check("idle_busy_msb", {7'b0, busy_m}, 8'd0);
    @(posedge clk); #1;

    // Backpressure on bit 2 of 8'h3C
    put_lsb(8'h3C, '{0,0,1,1,1,1,0,0});
    repeat (2) begin @(posedge clk); #1; end
    ser_ready_l = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bp_sel", {5'b0, sel_l}, 8'd2);
      check("bp_bit", {7'b0, ser_bit_l}, 8'd1);
      check("bp_valid", {7'b0, ser_valid_l}, 8'd1);
      @(posedge clk); #1;
    end
    ser_ready_l = 1'b1;
    drain();
    @(posedge clk); #1;

    // Back-to-back 8'hFF then 8'h00
    push_lsb('{1,1,1,1,1,1,1,1});
    push_lsb('{0,0,0,0,0,0,0,0});
    in_data_l  = 8'hFF;
    in_valid_l = 1'b1;
    caps = 0;
    k = 0;
    for (int c = 0; c < 40 && caps < 2; c++) begin
      @(negedge clk);
      if (caps == 1) begin
        check("b2b_valid", {7'b0, ser_valid_l}, 8'd1);
        check("b2b_in_ready", {7'b0, in_ready_l}, {7'b0, (k == 7)});
        k++;
      end
      if (in_ready_l) caps++;
      @(posedge clk); #1;
      if (caps == 1) in_data_l = 8'h00;
      if (caps == 2) in_valid_l = 1'b0;
    end
    check("b2b_captures", 8'(caps), 8'd2);
    in_valid_l = 1'b0;
    // Second word must start with no idle cycle.
    @(negedge clk);
    check("b2b_no_bubble", {7'b0, ser_valid_l}, 8'd1);
    drain();
    @(posedge clk); #1;

    // Mid-word reset during bit 4 of 8'h5A
    put_lsb(8'h5A, '{0,1,0,1,1,0,1,0});
    repeat (4) begin @(posedge clk); #1; end
    check("mid_sel_before_rst", {5'b0, sel_l}, 8'd4);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {7'b0, ser_valid_l}, 8'd0);
    check("mid_rst_busy", {7'b0, busy_l}, 8'd0);
    check("mid_rst_bit", {7'b0, ser_bit_l}, 8'd0);
    check("mid_rst_in_ready", {7'b0, in_ready_l}, 8'd1);
    check("mid_rst_sel", {5'b0, sel_l}, 8'd0);
    q_l.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    put_lsb(8'h01, '{1,0,0,0,0,0,0,0});
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_mux_serializer
